tb4004_cycle_sequencer: RTL and testbench

//  Master timing controller for the TB4004 core. Generates the 8-phase

---
 rtl/tb4004_pkg.sv | 31 +++
 rtl/tb4004_opcode_len.sv | 24 ++
 rtl/tb4004_cycle_sequencer.sv | 145 ++++++++++++++
 tb/tb_tb4004_cycle_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tb4004_pkg.sv
// Shared TB4004 timing and opcode definitions: phase numbering, first-word opcode
// nibbles and the cycle sequencer state encoding.
package tb4004_pkg;

    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // OPR nibbles; FIM/SRC and FIN/JIN share an OPR and differ by OPA[0]
    localparam logic [3:0] OPR_NOP = 4'h0;
    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_FIN = 4'h3;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_INC = 4'h6;
    localparam logic [3:0] OPR_ISZ = 4'h7;
    localparam logic [3:0] OPR_LDM = 4'hD;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN1 = 2'd1,
        ST_RUN2 = 2'd2
    } state_e;

endpackage

// File: rtl/tb4004_opcode_len.sv
// Combinational instruction-length decode: high when OPR/OPA start a two-word
// instruction (JCN, FIM, JUN, JMS, ISZ).
module tb4004_opcode_len
    import tb4004_pkg::*;
(
    input  logic [3:0] opr,
    input  logic [3:0] opa,
    output logic       two_word
);

    // Only OPA[0] separates FIM (two words) from SRC (one word)
    logic opa_unused;
    assign opa_unused = ^opa[3:1];

    always_comb begin
        two_word = 1'b0;
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two_word = 1'b1;
            OPR_FIM:                            two_word = ~opa[0];
            default:                            two_word = 1'b0;
        endcase
    end

endmodule

// File: rtl/tb4004_cycle_sequencer.sv
// TB4004 master timing: 8-phase instruction cycle, OPR/OPA capture, two-word
// sequencing and run/halt control. Optional single-step: TB4004_SINGLE_STEP_EN.
module tb4004_cycle_sequencer
    import tb4004_pkg::*;
(
    input  logic       clk,
    input  logic       rstN,
    input  logic       runEn,
`ifdef TB4004_SINGLE_STEP_EN
    input  logic       stepReq,
`endif
    input  logic [3:0] romData,
    output logic [2:0] cycle,
    output logic       sync,
    output logic       pcInc,
    output logic [3:0] opr,
    output logic [3:0] opa,
    output logic [3:0] opr2,
    output logic [3:0] opa2,
    output logic       secondWord,
    output logic       execValid,
    output logic       instrDone,
    output logic       halted
);

    state_e     state_q, state_d;
    logic [2:0] cycle_q, cycle_d;
    logic [3:0] opr_q, opr_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] opr2_q, opr2_d;
    logic [3:0] opa2_q, opa2_d;
    logic       two_word;
    logic       keep_running;

    tb4004_opcode_len u_len (
        .opr      (opr_q),
        .opa      (opa_q),
        .two_word (two_word)
    );

`ifdef TB4004_SINGLE_STEP_EN
    logic step_q, step_d;
    // A stepped instruction always falls back to HALT at its final X3
    assign keep_running = runEn & ~step_q;
`else
    assign keep_running = runEn;
`endif

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        opr_d   = opr_q;
        opa_d   = opa_q;
        opr2_d  = opr2_q;
        opa2_d  = opa2_q;
`ifdef TB4004_SINGLE_STEP_EN
        step_d  = step_q;
`endif
        case (state_q)
            ST_HALT: begin
                cycle_d = CYC_A1;
                if (runEn) begin
                    state_d = ST_RUN1;
`ifdef TB4004_SINGLE_STEP_EN
                end else if (stepReq) begin
                    state_d = ST_RUN1;
                    step_d  = 1'b1;
`endif
                end
            end
            ST_RUN1: begin
                cycle_d = cycle_q + 3'd1;
                if (cycle_q == CYC_M1) opr_d = romData;
                if (cycle_q == CYC_M2) opa_d = romData;
                if (cycle_q == CYC_X3) begin
                    if (two_word) begin
                        state_d = ST_RUN2;
                    end else begin
                        state_d = keep_running ? ST_RUN1 : ST_HALT;
`ifdef TB4004_SINGLE_STEP_EN
                        step_d  = 1'b0;
`endif
                    end
                end
            end
            ST_RUN2: begin
                cycle_d = cycle_q + 3'd1;
                if (cycle_q == CYC_M1) opr2_d = romData;
                if (cycle_q == CYC_M2) opa2_d = romData;
                if (cycle_q == CYC_X3) begin
                    state_d = keep_running ? ST_RUN1 : ST_HALT;
`ifdef TB4004_SINGLE_STEP_EN
                    step_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_HALT;
                cycle_d = CYC_A1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= ST_HALT;
            cycle_q <= CYC_A1;
            opr_q   <= 4'h0;
            opa_q   <= 4'h0;
            opr2_q  <= 4'h0;
            opa2_q  <= 4'h0;
`ifdef TB4004_SINGLE_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            opr_q   <= opr_d;
            opa_q   <= opa_d;
            opr2_q  <= opr2_d;
            opa2_q  <= opa2_d;
`ifdef TB4004_SINGLE_STEP_EN
            step_q  <= step_d;
`endif
        end
    end

    logic run;
    logic final_word;
    assign run        = (state_q != ST_HALT);
    assign final_word = ((state_q == ST_RUN1) & ~two_word) | (state_q == ST_RUN2);

    assign cycle      = cycle_q;
    assign opr        = opr_q;
    assign opa        = opa_q;
    assign opr2       = opr2_q;
    assign opa2       = opa2_q;
    assign sync       = run & (cycle_q == CYC_X3);
    assign pcInc      = run & (cycle_q == CYC_A3);
    assign secondWord = (state_q == ST_RUN2);
    assign execValid  = (cycle_q >= CYC_X1) & final_word;
    assign instrDone  = (cycle_q == CYC_X3) & final_word;
    assign halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_tb4004_cycle_sequencer.sv
// Directed bench for tb4004_cycle_sequencer: drives ROM nibbles per phase and
// checks sequencing, capture timing, halt and reset behaviour.
module tb_tb4004_cycle_sequencer;

    logic       clk;
    logic       rstN;
    logic       runEn;
    logic [3:0] romData;
    logic [2:0] cycle;
    logic       sync, pcInc, secondWord, execValid, instrDone, halted;
    logic [3:0] opr, opa, opr2, opa2;
`ifdef TB4004_SINGLE_STEP_EN
    logic       stepReq;
    int         step_at;
`endif

    int n_asrt;
    int n_fail;

    logic [7:0] s_cyc[8], s_opr[8], s_opa[8], s_opr2[8], s_opa2[8];
    logic [7:0] s_sw[8], s_ev[8], s_done[8], s_pc[8], s_sync[8], s_hlt[8];

    tb4004_cycle_sequencer dut (
        .clk        (clk),
        .rstN       (rstN),
        .runEn      (runEn),
`ifdef TB4004_SINGLE_STEP_EN
        .stepReq    (stepReq),
`endif
        .romData    (romData),
        .cycle      (cycle),
        .sync       (sync),
        .pcInc      (pcInc),
        .opr        (opr),
        .opa        (opa),
        .opr2       (opr2),
        .opa2       (opa2),
        .secondWord (secondWord),
        .execValid  (execValid),
        .instrDone  (instrDone),
        .halted     (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    // One instruction word: entered at cycle 0, leaves just after the X3 edge
    task automatic word(input logic [3:0] hi, input logic [3:0] lo, input int drop_at);
        for (int c = 0; c < 8; c++) begin
            romData = (c < 4) ? hi : lo;
            if (c == drop_at) runEn = 1'b0;
`ifdef TB4004_SINGLE_STEP_EN
            stepReq = (c == step_at);
`endif
            s_cyc[c]  = {5'd0, cycle};
            s_opr[c]  = {4'd0, opr};
            s_opa[c]  = {4'd0, opa};
            s_opr2[c] = {4'd0, opr2};
            s_opa2[c] = {4'd0, opa2};
            s_sw[c]   = {7'd0, secondWord};
            s_ev[c]   = {7'd0, execValid};
            s_done[c] = {7'd0, instrDone};
            s_pc[c]   = {7'd0, pcInc};
            s_sync[c] = {7'd0, sync};
            s_hlt[c]  = {7'd0, halted};
            tick();
        end
`ifdef TB4004_SINGLE_STEP_EN
        stepReq = 1'b0;
`endif
    endtask

    task automatic chk_halt_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_cyc"}, i, {5'd0, cycle}, 8'd0);
            chk({tag, "_hlt"}, i, {7'd0, halted}, 8'd1);
            chk({tag, "_sync"}, i, {7'd0, sync}, 8'd0);
            tick();
        end
    endtask

    initial begin
        n_asrt  = 0;
        n_fail  = 0;
        rstN    = 1'b0;
        runEn   = 1'b0;
        romData = 4'h0;
`ifdef TB4004_SINGLE_STEP_EN
        stepReq = 1'b0;
        step_at = -1;
`endif
        #2;
        chk("rst_cyc", 0, {5'd0, cycle}, 8'd0);
        chk("rst_hlt", 0, {7'd0, halted}, 8'd1);
        chk("rst_opr", 0, {opr, opa}, 8'h00);
        chk("rst_w2", 0, {opr2, opa2}, 8'h00);
        chk("rst_strb", 0, {3'd0, secondWord, execValid, instrDone, sync, pcInc}, 8'd0);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        chk("idle_hlt", 0, {7'd0, halted}, 8'd1);

        // 1: LDM 5
        runEn = 1'b1;
        tick();
        word(4'hD, 4'h5, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t1_cyc", c, s_cyc[c], 8'(c));
            chk("t1_opr", c, s_opr[c], (c >= 4) ? 8'hD : 8'h0);
            chk("t1_opa", c, s_opa[c], (c >= 5) ? 8'h5 : 8'h0);
            chk("t1_ev", c, s_ev[c], (c >= 5) ? 8'd1 : 8'd0);
            chk("t1_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
            chk("t1_sw", c, s_sw[c], 8'd0);
            chk("t1_sync", c, s_sync[c], (c == 7) ? 8'd1 : 8'd0);
            chk("t1_hlt", c, s_hlt[c], 8'd0);
        end

        // 2: JUN 0x41,0x23
        word(4'h4, 4'h1, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t2a_opr", c, s_opr[c], (c >= 4) ? 8'h4 : 8'hD);
            chk("t2a_opa", c, s_opa[c], (c >= 5) ? 8'h1 : 8'h5);
            chk("t2a_ev", c, s_ev[c], 8'd0);
            chk("t2a_done", c, s_done[c], 8'd0);
            chk("t2a_pc", c, s_pc[c], (c == 2) ? 8'd1 : 8'd0);
            chk("t2a_sw", c, s_sw[c], 8'd0);
        end
        word(4'h2, 4'h3, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t2b_cyc", c, s_cyc[c], 8'(c));
            chk("t2b_sw", c, s_sw[c], 8'd1);
            chk("t2b_opr", c, {s_opr[c][3:0], s_opa[c][3:0]}, 8'h41);
            chk("t2b_opr2", c, s_opr2[c], (c >= 4) ? 8'h2 : 8'h0);
            chk("t2b_opa2", c, s_opa2[c], (c >= 5) ? 8'h3 : 8'h0);
            chk("t2b_ev", c, s_ev[c], (c >= 5) ? 8'd1 : 8'd0);
            chk("t2b_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
            chk("t2b_pc", c, s_pc[c], (c == 2) ? 8'd1 : 8'd0);
        end

        // 3: FIM 0x20 takes two words, SRC 0x21 one
        word(4'h2, 4'h0, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t3fim_ev", c, s_ev[c], 8'd0);
            chk("t3fim_done", c, s_done[c], 8'd0);
        end
        word(4'h0, 4'h0, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t3fim2_sw", c, s_sw[c], 8'd1);
            chk("t3fim2_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
        end
        word(4'h2, 4'h1, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t3src_sw", c, s_sw[c], 8'd0);
            chk("t3src_ev", c, s_ev[c], (c >= 5) ? 8'd1 : 8'd0);
            chk("t3src_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
        end
        chk("t3src_next", 0, {6'd0, secondWord, halted}, 8'd0);

        // 4: JMS with runEn dropped at RUN1 M1
        word(4'h5, 4'h0, 3);
        chk("t4_enter2", 0, {6'd0, secondWord, halted}, 8'd2);
        word(4'h1, 4'h2, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t4b_sw", c, s_sw[c], 8'd1);
            chk("t4b_hlt", c, s_hlt[c], 8'd0);
            chk("t4b_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
        end
        chk_halt_idle("t4_halt", 3);

        // 5: async reset in RUN2 M2
        runEn = 1'b1;
        tick();
        word(4'h4, 4'h1, -1);
        for (int c = 0; c < 4; c++) begin
            romData = 4'h2;
            tick();
        end
        chk("t5_pre", 0, {4'd0, secondWord, cycle}, 8'h0C);
        rstN = 1'b0;
        #1;
        chk("t5_cyc", 0, {5'd0, cycle}, 8'd0);
        chk("t5_hlt", 0, {7'd0, halted}, 8'd1);
        chk("t5_opr", 0, {opr, opa}, 8'h00);
        chk("t5_w2", 0, {opr2, opa2}, 8'h00);
        chk("t5_strb", 0, {3'd0, secondWord, execValid, instrDone, sync, pcInc}, 8'd0);
        tick();
        rstN = 1'b1;
        tick();
        word(4'hD, 4'h5, -1);
        for (int c = 0; c < 8; c++) begin
            chk("t5r_cyc", c, s_cyc[c], 8'(c));
            chk("t5r_sw", c, s_sw[c], 8'd0);
            chk("t5r_opr", c, s_opr[c], (c >= 4) ? 8'hD : 8'h0);
            chk("t5r_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
        end

`ifdef TB4004_SINGLE_STEP_EN
        // 6: single step over ISZ 0x70,0x10
        runEn = 1'b0;
        word(4'h0, 4'h0, -1);
        chk_halt_idle("t6_idle", 2);
        stepReq = 1'b1;
        tick();
        stepReq = 1'b0;
        chk("t6_go", 0, {4'd0, halted, cycle}, 8'h00);
        step_at = 2;
        word(4'h7, 4'h0, -1);
        step_at = -1;
        for (int c = 0; c < 8; c++) chk("t6a_sw", c, s_sw[c], 8'd0);
        step_at = 5;
        word(4'h1, 4'h0, -1);
        step_at = -1;
        for (int c = 0; c < 8; c++) begin
            chk("t6b_sw", c, s_sw[c], 8'd1);
            chk("t6b_done", c, s_done[c], (c == 7) ? 8'd1 : 8'd0);
        end
        chk_halt_idle("t6_halt", 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
